retire_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single retire-stage input (value_in, comp_result_in, op_in)

---
 rtl/retire_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_retire_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_arbiter.sv
// -----------------------------------------------------------------------------
// retire_arbiter
//
// Round-robin arbiter that shares the single retire-stage input between
// NUM_REQ functional-unit result producers. The granted result is registered
// (one cycle of latency), held while retire stalls, and replaced by bubbles for
// FLUSH_CYCLES cycles after a mispredicted branch.
//
// Ports
//   clk                 : clock, rising edge
//   rst                 : synchronous reset, active-low
//   req_valid[i]        : FU i has a completed result
//   req_ready[i]        : FU i result accepted this cycle (one-hot or zero)
//   req_value[i]        : FU i result value
//   req_comp_result[i]  : FU i branch compare result
//   req_op[i]           : FU i originating reservation-station cell
//   retire_stall        : retire cannot accept a new op this cycle
//   mispredicted_branch : flush request from retire
//   value_out           : registered value to retire
//   comp_result_out     : registered compare result to retire
//   op_out              : registered RS cell to retire (busy=0 is a bubble)
//   arb_state           : debug view of the control state (00 RUN, 01 STALL, 10 FLUSH)
// -----------------------------------------------------------------------------
package retire_arbiter_pkg;

    typedef logic [31:0] phy_rf_data_t;

    typedef struct packed {
        logic       busy;
        logic [5:0] dest;
        logic [3:0] rob_addr;
        logic [4:0] opcode;
    } res_st_cell_t;

endpackage

module retire_arbiter
    import retire_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  phy_rf_data_t        req_value [NUM_REQ],
    input  logic [NUM_REQ-1:0]  req_comp_result,
    input  res_st_cell_t        req_op [NUM_REQ],
    input  logic                retire_stall,
    input  logic                mispredicted_branch,
    output phy_rf_data_t        value_out,
    output logic                comp_result_out,
    output res_st_cell_t        op_out,
    output logic [1:0]          arb_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_RELOAD  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]   flush_cnt_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_next;

    logic               grant_en;
    logic               grant_found;
    logic               grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;

    logic               out_load;
    logic               out_clear;

    // Modular add for pointer arithmetic; the extra bit keeps the sum exact so
    // a non-power-of-two NUM_REQ wraps correctly.
    function automatic logic [PTR_W-1:0] wrap_add(
        input logic [PTR_W-1:0] base,
        input logic [PTR_W-1:0] offs
    );
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= NUM_REQ_EXT) begin
            sum = sum - NUM_REQ_EXT;
        end
        return sum[PTR_W-1:0];
    endfunction

    // A STALL cycle with the stall released behaves exactly like RUN, which
    // lets the first grant happen in that same cycle instead of a dead cycle.
    assign grant_en = rst && !mispredicted_branch && !retire_stall &&
                      ((state == ST_RUN) || (state == ST_STALL));

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr, PTR_W'(k));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = grant_en && grant_found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic. Flush outranks everything; stall only freezes outputs.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        rr_ptr_next    = rr_ptr;
        out_load       = 1'b0;
        out_clear      = 1'b0;

        if (mispredicted_branch) begin
            state_next     = ST_FLUSH;
            flush_cnt_next = CNT_RELOAD;
            out_clear      = 1'b1;
        end else begin
            unique case (state)
                ST_RUN, ST_STALL: begin
                    if (retire_stall) begin
                        state_next = ST_STALL;
                    end else begin
                        state_next = ST_RUN;
                        if (grant) begin
                            out_load    = 1'b1;
                            rr_ptr_next = wrap_add(grant_idx, PTR_ONE);
                        end else begin
                            out_clear   = 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    out_clear = 1'b1;
                    if (flush_cnt == '0) begin
                        state_next = ST_RUN;
                    end else begin
                        flush_cnt_next = flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    out_clear  = 1'b1;
                end
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            rr_ptr    <= rr_ptr_next;
        end
    end

    // Retire-facing output registers; neither load nor clear means hold.
    always_ff @(posedge clk) begin
        if (!rst || out_clear) begin
            value_out       <= '0;
            comp_result_out <= 1'b0;
            op_out          <= '0;
        end else if (out_load) begin
            value_out       <= req_value[grant_idx];
            comp_result_out <= req_comp_result[grant_idx];
            op_out          <= req_op[grant_idx];
            op_out.busy     <= 1'b1;
        end
    end

    assign arb_state = state;

endmodule

// File: tb/tb_retire_arbiter.sv
// -----------------------------------------------------------------------------
// tb_retire_arbiter
//
// Directed scenarios for reset, round robin, sparse requests, stall, flush and
// back-to-back flush, followed by a randomized run checked against a
// behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_retire_arbiter;
    import retire_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int FC = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    phy_rf_data_t req_value [N];
    logic [N-1:0] req_comp_result;
    res_st_cell_t req_op [N];
    logic         retire_stall;
    logic         mispredicted_branch;
    phy_rf_data_t value_out;
    logic         comp_result_out;
    res_st_cell_t op_out;
    logic [1:0]   arb_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: mode 0 RUN, 1 STALL, 2 FLUSH
    int           m_mode = 0;
    int           m_ptr  = 0;
    int           m_cnt  = 0;
    phy_rf_data_t m_val  = '0;
    logic         m_comp = 1'b0;
    res_st_cell_t m_op   = '0;

    retire_arbiter #(.NUM_REQ(N), .FLUSH_CYCLES(FC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_value           (req_value),
        .req_comp_result     (req_comp_result),
        .req_op              (req_op),
        .retire_stall        (retire_stall),
        .mispredicted_branch (mispredicted_branch),
        .value_out           (value_out),
        .comp_result_out     (comp_result_out),
        .op_out              (op_out),
        .arb_state           (arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner this cycle per the rules, or -1 when nothing may be accepted.
    function automatic int m_winner();
        if (!rst || mispredicted_branch || retire_stall || m_mode == 2) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(input int w);
        logic [N-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic m_clear();
        m_val  = '0;
        m_comp = 1'b0;
        m_op   = '0;
    endtask

    task automatic m_apply(input int w);
        if (!rst) begin
            m_mode = 0; m_ptr = 0; m_cnt = 0; m_clear();
        end else if (mispredicted_branch) begin
            m_mode = 2; m_cnt = FC - 1; m_clear();
        end else if (m_mode == 2) begin
            m_clear();
            if (m_cnt == 0) m_mode = 0;
            else m_cnt = m_cnt - 1;
        end else if (retire_stall) begin
            m_mode = 1;
        end else begin
            m_mode = 0;
            if (w >= 0) begin
                m_val     = req_value[w];
                m_comp    = req_comp_result[w];
                m_op      = req_op[w];
                m_op.busy = 1'b1;
                m_ptr     = (w + 1) % N;
            end else begin
                m_clear();
            end
        end
    endtask

    // Advance one clock; inputs are held across the edge and the model follows.
    task automatic tick();
        int w;
        w = m_winner();
        @(posedge clk);
        m_apply(w);
        #1;
    endtask

    task automatic set_payload(input int i, input int val, input int dest, input int rob);
        req_value[i]       = phy_rf_data_t'(val);
        req_comp_result[i] = 1'b0;
        req_op[i]          = '0;
        req_op[i].dest     = 6'(dest);
        req_op[i].rob_addr = 4'(rob);
        req_op[i].opcode   = 5'(i + 1);
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '1; retire_stall = 1'b0; mispredicted_branch = 1'b0;
        for (int i = 0; i < N; i++) set_payload(i, 100 + i, i, i);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
            end
            tick();
            n_checks++;
            if (op_out !== res_st_cell_t'(0) || value_out !== 32'd0) begin
                n_errors++; $display("FAIL reset_out: got op %h val %h expected 0", op_out, value_out);
            end
            n_checks++;
            if (arb_state !== 2'b00) begin
                n_errors++; $display("FAIL reset_state: got %b expected 00", arb_state);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            logic [N-1:0] er;
            er = '0;
            er[exp_g[c]] = 1'b1;
            #1;
            n_checks++;
            if (req_ready !== er) begin
                n_errors++; $display("FAIL rr_ready%0d: got %b expected %b", c, req_ready, er);
            end
            tick();
            n_checks++;
            if (value_out !== phy_rf_data_t'(100 + exp_g[c]) || op_out.busy !== 1'b1 ||
                op_out.dest !== 6'(exp_g[c])) begin
                n_errors++; $display("FAIL rr_out%0d: got val %0d busy %b dest %0d expected %0d 1 %0d",
                                     c, value_out, op_out.busy, op_out.dest, 100 + exp_g[c], exp_g[c]);
            end
        end
    endtask

    task automatic test_sparse();
        req_valid = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_payload(2, 15, 9, 1);
        set_payload(0, 8, 4, 2);
        req_valid = 4'b0101;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_errors++; $display("FAIL sparse_ready0: got %b expected 0001", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        n_checks++;
        if (value_out !== 32'd8 || op_out.rob_addr !== 4'd2 || op_out.busy !== 1'b1) begin
            n_errors++; $display("FAIL sparse_out0: got val %0d rob %0d expected 8 2", value_out, op_out.rob_addr);
        end
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_errors++; $display("FAIL sparse_ready1: got %b expected 0100", req_ready);
        end
        tick();
        req_valid[2] = 1'b0;
        n_checks++;
        if (value_out !== 32'd15 || op_out.rob_addr !== 4'd1) begin
            n_errors++; $display("FAIL sparse_out1: got val %0d rob %0d expected 15 1", value_out, op_out.rob_addr);
        end
        tick();
        n_checks++;
        if (op_out !== res_st_cell_t'(0) || value_out !== 32'd0) begin
            n_errors++; $display("FAIL sparse_bubble: got op %h val %h expected 0", op_out, value_out);
        end
    endtask

    task automatic test_stall();
        set_payload(1, 21, 3, 5);
        set_payload(3, 23, 7, 6);
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_errors++; $display("FAIL stall_grant: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        retire_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_errors++; $display("FAIL stall_ready%0d: got %b expected 0000", c, req_ready);
            end
            tick();
            n_checks++;
            if (op_out.dest !== 6'd3 || op_out.busy !== 1'b1 || value_out !== 32'd21 || arb_state !== 2'b01) begin
                n_errors++; $display("FAIL stall_hold%0d: got dest %0d busy %b state %b expected 3 1 01",
                                     c, op_out.dest, op_out.busy, arb_state);
            end
        end
        retire_stall = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_errors++; $display("FAIL stall_resume: got %b expected 1000", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (op_out.dest !== 6'd7 || arb_state !== 2'b00) begin
            n_errors++; $display("FAIL stall_after: got dest %0d state %b expected 7 00", op_out.dest, arb_state);
        end
    endtask

    task automatic test_flush();
        set_payload(0, 40, 11, 3);
        req_valid = 4'b0001;
        retire_stall = 1'b1;
        tick();
        mispredicted_branch = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000 || arb_state !== 2'b01) begin
            n_errors++; $display("FAIL flush_pulse: got ready %b state %b expected 0000 01", req_ready, arb_state);
        end
        tick();
        mispredicted_branch = 1'b0;
        retire_stall = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (op_out.busy !== 1'b0 || arb_state !== 2'b10) begin
                n_errors++; $display("FAIL flush_state%0d: got busy %b state %b expected 0 10", c, op_out.busy, arb_state);
            end
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_errors++; $display("FAIL flush_ready%0d: got %b expected 0000", c, req_ready);
            end
            tick();
        end
        n_checks++;
        if (arb_state !== 2'b00 || op_out.busy !== 1'b0) begin
            n_errors++; $display("FAIL flush_exit: got state %b busy %b expected 00 0", arb_state, op_out.busy);
        end
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_errors++; $display("FAIL flush_regrant: got %b expected 0001", req_ready);
        end
        tick();
        n_checks++;
        if (op_out.busy !== 1'b1 || value_out !== 32'd40) begin
            n_errors++; $display("FAIL flush_regrant_out: got busy %b val %0d expected 1 40", op_out.busy, value_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_st [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        logic       pulse  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            mispredicted_branch = pulse[c];
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_errors++; $display("FAIL b2b_ready%0d: got %b expected 0000", c, req_ready);
            end
            tick();
            mispredicted_branch = 1'b0;
            n_checks++;
            if (arb_state !== exp_st[c] || op_out.busy !== 1'b0) begin
                n_errors++; $display("FAIL b2b_state%0d: got state %b busy %b expected %b 0",
                                     c, arb_state, op_out.busy, exp_st[c]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] er;
            rst                 = ($urandom_range(0, 39) != 0);
            mispredicted_branch = ($urandom_range(0, 15) == 0);
            retire_stall        = ($urandom_range(0, 3) == 0);
            req_valid           = N'($urandom);
            req_comp_result     = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_value[i] = $urandom;
                req_op[i]    = res_st_cell_t'(16'($urandom));
            end
            #1;
            er = m_ready(m_winner());
            n_checks++;
            if (req_ready !== er) begin
                n_errors++; $display("FAIL rand_ready%0d: got %b expected %b", c, req_ready, er);
            end
            tick();
            n_checks++;
            if (value_out !== m_val || comp_result_out !== m_comp || op_out !== m_op) begin
                n_errors++; $display("FAIL rand_out%0d: got %h/%b/%h expected %h/%b/%h",
                                     c, value_out, comp_result_out, op_out, m_val, m_comp, m_op);
            end
            n_checks++;
            if (arb_state !== 2'(m_mode)) begin
                n_errors++; $display("FAIL rand_state%0d: got %b expected %0d", c, arb_state, m_mode);
            end
        end
    endtask

    initial begin
        rst                 = 1'b0;
        req_valid           = '0;
        req_comp_result     = '0;
        retire_stall        = 1'b0;
        mispredicted_branch = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_value[i] = '0;
            req_op[i]    = '0;
        end
        test_reset();
        test_round_robin();
        test_sparse();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
